mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Memory-access stage that consumes the EX/MEM pipeline register outputs and drives the data-memory bus. It issues one load/store per instruction over a valid/ready request and response handshake, and stalls the pipeline until the transaction completes. It aligns and sign-extends load data and applies byte/halfword store strobes. Results are registered into the MEM/WB pipeline register (the W-side outputs).

Parameters:
XLEN, 32, datapath and address width; only 32 is supported.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ALUResultM  in  32  effective address, or ALU result for non-memory ops
WriteDataM  in  32  store data (rs2)
RdM  in  5  destination register
PCPlus4M  in  32  PC+4 of the instruction
Funct3M  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
MemReadM  in  1  load
MemWriteM  in  1  store
RegWriteM  in  1  writeback enable
StallM  out  1  holds IF/ID/EX/M stages
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts request
dmem_we  out  1  1 = store
dmem_addr  out  32  word-aligned address {ALUResultM[31:2],2'b00}
dmem_wdata  out  32  replicated store data
dmem_wstrb  out  4  byte enables
dmem_rsp_valid  in  1  response/ack valid (loads and stores)
dmem_rdata  in  32  load word
ALUResultW, ReadDataW, PCPlus4W  out  32  MEM/WB register
RdW  out  5  MEM/WB register
RegWriteW  out  1  MEM/WB register
MisalignW  out  1  fault flag for the retiring instruction

Behaviour:
- Reset: asynchronous. All outputs are 0 and the FSM is in IDLE. Reset mid-transaction drops dmem_req_valid immediately. A dmem_rsp_valid arriving in IDLE is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE, memory op present and legal: StallM=1. Address, we, wdata and wstrb are registered. Go to REQ.
- REQ: dmem_req_valid=1 and all request fields stay stable. StallM=1. Go to RESP on dmem_req_ready.
- RESP: StallM=1 until dmem_rsp_valid. In the rsp cycle, StallM=0, the MEM/WB register captures, and the FSM goes to IDLE.
- Minimum latency for a memory op is 3 cycles in M (ready and rsp each arrive in the first cycle they can).
- Non-memory op (MemReadM=MemWriteM=0): StallM=0, one-cycle pass-through into the MEM/WB register. ReadDataW=0.
- MEM/WB update:
  - StallM=0: capture the instruction (ALUResultM, aligned load data, RdM, PCPlus4M, RegWriteM).
  - StallM=1: insert a bubble (RegWriteW=0, RdW=0, MisalignW=0).
- Misaligned or illegal access: no bus request and no stall. Writeback happens next cycle with RegWriteW=0 and MisalignW=1 for one cycle. Cases:
  - halfword with addr[0]=1
  - word with addr[1:0]≠0
  - unsupported Funct3 (011, 110, 111)
- MemReadM and MemWriteM both 1: treated as a store.
- Store formatting (addr[1:0]=a):
  - SB: wstrb=4'b0001<<a, wdata={4{WriteDataM[7:0]}}
  - SH: wstrb=0011 (a=0) or 1100 (a=2), wdata={2{WriteDataM[15:0]}}
  - SW: wstrb=1111, wdata=WriteDataM
  - Loads: wstrb=0000, we=0.
- Load extraction: select byte/half by a.
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word.
  - Stores write ReadDataW=0.

Decomposition:
- Package mem_pkg:
  - Funct3 encodings: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state enum: IDLE/REQ/RESP.
  - Alignment-check function.
- One combinational sub-module, lsu_align: store strobe/data formatting plus load extract/extend.

Test Plan:
- Pass-through: ALUResultM=0x00001234, RdM=5, RegWriteM=1, no mem op -> next cycle ALUResultW=0x1234, RdW=5, RegWriteW=1; StallM never asserted.
- Load with sign: LB at 0x1003, ready in REQ's first cycle, rsp next cycle with rdata=0x80FF0000 -> dmem_addr=0x1000, ReadDataW=0xFFFFFF80, StallM high exactly 2 cycles. Same stimulus with LBU -> 0x00000080.
- Store halfword: SH at 0x2002, WriteDataM=0x0000ABCD -> dmem_we=1, addr=0x2000, wstrb=1100, wdata=0xABCDABCD; RegWriteW from RegWriteM (0).
- Backpressure: dmem_req_ready low 5 cycles -> req_valid and all request fields stable for 5 cycles; StallM high throughout; MEM/WB shows bubbles (RegWriteW=0).
- Misalign: LW at 0x3001 -> no dmem_req_valid, StallM=0, next cycle MisalignW=1, RegWriteW=0.
- Reset in RESP: assert reset -> all outputs 0 and state IDLE. A later dmem_rsp_valid pulse produces no MEM/WB write.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access encodings,
// FSM states and the alignment/legality check.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } lsu_state_t;

  // 1 when the access size is supported and the address is naturally aligned
  function automatic logic access_ok(input logic [2:0] funct3, input logic [1:0] a);
    case (funct3)
      F3_B, F3_BU: access_ok = 1'b1;
      F3_H, F3_HU: access_ok = ~a[0];
      F3_W:        access_ok = (a == 2'b00);
      default:     access_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational data formatting: store byte-lane replication and strobes,
// load byte/halfword extraction with sign or zero extension.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    wstrb     = '0;
    wdata     = store_data;
    load_data = '0;
    rbyte     = '0;
    rhalf     = '0;

    // Store size comes from funct3[1:0]; the sign bit has no meaning for stores
    case (funct3[1:0])
      2'b00: begin
        wstrb = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        wstrb = offset[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: wstrb = 4'b1111;
    endcase

    case (offset)
      2'd0:    rbyte = rdata[7:0];
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      default: rbyte = rdata[31:24];
    endcase
    rhalf = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    load_data = {{24{rbyte[7]}}, rbyte};
      F3_BU:   load_data = {24'd0, rbyte};
      F3_H:    load_data = {{16{rhalf[15]}}, rhalf};
      F3_HU:   load_data = {16'd0, rhalf};
      F3_W:    load_data = rdata;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: issues one data-memory transaction per load/store,
// stalls until the response, and registers the MEM/WB pipeline outputs.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [4:0]      RdM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [2:0]      Funct3M,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic            RegWriteM,
  output logic            StallM,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [4:0]      RdW,
  output logic            RegWriteW,
  output logic            MisalignW
);

  lsu_state_t state_q, state_d;

  logic        is_mem;
  logic        legal;
  logic        issue;
  logic        misalign;
  logic        stall;
  logic [3:0]  fmt_wstrb;
  logic [31:0] fmt_wdata;
  logic [31:0] load_data;

  assign is_mem   = MemReadM | MemWriteM;
  assign legal    = access_ok(Funct3M, ALUResultM[1:0]);
  assign issue    = (state_q == IDLE) && is_mem && legal;
  assign misalign = (state_q == IDLE) && is_mem && !legal;

  lsu_align u_align (
    .funct3     (Funct3M),
    .offset     (ALUResultM[1:0]),
    .store_data (WriteDataM),
    .rdata      (dmem_rdata),
    .wstrb      (fmt_wstrb),
    .wdata      (fmt_wdata),
    .load_data  (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mem && legal) begin
          stall   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dmem_req_ready) state_d = RESP;
      end
      RESP: begin
        if (dmem_rsp_valid) state_d = IDLE;
        else                stall   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall is combinational from the held M inputs, so mask it during reset
  assign StallM         = stall & ~reset;
  assign dmem_req_valid = (state_q == REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_addr  <= '0;
      dmem_we    <= 1'b0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
    end else if (issue) begin
      dmem_addr  <= {ALUResultM[XLEN-1:2], 2'b00};
      dmem_we    <= MemWriteM;
      dmem_wdata <= MemWriteM ? fmt_wdata : '0;
      dmem_wstrb <= MemWriteM ? fmt_wstrb : '0;
    end
  end

  // MEM/WB register; M inputs are held while stalled, so the aligner sees
  // the in-flight instruction's size and offset in the response cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      MisalignW  <= 1'b0;
    end else if (stall) begin
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      MisalignW  <= 1'b0;
    end else begin
      ALUResultW <= ALUResultM;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
      RegWriteW  <= RegWriteM & ~misalign;
      MisalignW  <= misalign;
      ReadDataW  <= (state_q == RESP && !dmem_we) ? load_data : '0;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: a memory responder checks bus requests,
// a monitor checks every MEM/WB update against queued expectations.
module tb_mem_stage_lsu;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic [2:0]  Funct3M;
  logic        MemReadM, MemWriteM, RegWriteM;
  logic        StallM;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic        RegWriteW, MisalignW;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
    .PCPlus4M(PCPlus4M), .Funct3M(Funct3M), .MemReadM(MemReadM),
    .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .StallM(StallM),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rdata(dmem_rdata), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .PCPlus4W(PCPlus4W), .RdW(RdW), .RegWriteW(RegWriteW), .MisalignW(MisalignW)
  );

  typedef struct {
    logic [31:0] alu, rdata, pc;
    logic [4:0]  rd;
    logic        rw, mis;
  } wb_t;

  typedef struct {
    logic [31:0] addr, wdata;
    logic        we;
    logic [3:0]  wstrb;
  } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic legal_m(input logic [2:0] f3, input logic [1:0] a);
    if (f3 == 3'b000 || f3 == 3'b100) return 1'b1;
    if (f3 == 3'b001 || f3 == 3'b101) return (a[0] == 1'b0);
    if (f3 == 3'b010) return (a == 2'b00);
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_m(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] w);
    int ia;
    logic signed [31:0] s;
    ia = int'(a);
    case (f3)
      3'b000: begin s = $signed(w << (8 * (3 - ia))); return 32'(s >>> 24); end
      3'b001: begin s = $signed(w << (8 * (2 - ia))); return 32'(s >>> 16); end
      3'b100: return (w >> (8 * ia)) & 32'h0000_00FF;
      3'b101: return (w >> (8 * ia)) & 32'h0000_FFFF;
      3'b010: return w;
      default: return 32'h0;
    endcase
  endfunction

  // Responder controls
  logic        resp_en = 1'b1;
  logic        no_rsp = 1'b0;
  logic        accepted = 1'b0;
  logic        in_req = 1'b0;
  int          ready_dly = 0;
  int          wait_cnt = 0;
  logic [31:0] mem_rdata = '0;
  req_t        cur;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (resp_en) begin
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        if (accepted) begin
          if (!no_rsp) begin
            dmem_rsp_valid = 1'b1;
            dmem_rdata     = mem_rdata;
            accepted       = 1'b0;
          end
        end else if (dmem_req_valid) begin
          if (!in_req) begin
            if (req_q.size() == 0) begin
              check("spurious_req", 32'(dmem_req_valid), 32'd0);
              cur = '{addr: '0, wdata: '0, we: 1'b0, wstrb: '0};
            end else begin
              cur = req_q.pop_front();
            end
            in_req = 1'b1;
          end
          check("req_addr",  dmem_addr,         cur.addr);
          check("req_we",    32'(dmem_we),      32'(cur.we));
          check("req_wdata", dmem_wdata,        cur.wdata);
          check("req_wstrb", 32'(dmem_wstrb),   32'(cur.wstrb));
          if (wait_cnt >= ready_dly) begin
            dmem_req_ready = 1'b1;
            accepted       = 1'b1;
            in_req         = 1'b0;
            wait_cnt       = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // MEM/WB monitor: an unstalled cycle retires one expectation next cycle,
  // a stalled cycle must leave a bubble.
  logic mon_on = 1'b0;
  logic adv_prev = 1'b0;

  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (adv_prev) begin
          if (wb_q.size() == 0) begin
            check("sb_empty", 32'(wb_q.size()), 32'd1);
          end else begin
            e = wb_q.pop_front();
            check("wb_alu",   ALUResultW,      e.alu);
            check("wb_rdata", ReadDataW,       e.rdata);
            check("wb_pc",    PCPlus4W,        e.pc);
            check("wb_rd",    32'(RdW),        32'(e.rd));
            check("wb_rw",    32'(RegWriteW),  32'(e.rw));
            check("wb_mis",   32'(MisalignW),  32'(e.mis));
          end
        end else begin
          check("bubble_rw",  32'(RegWriteW), 32'd0);
          check("bubble_rd",  32'(RdW),       32'd0);
          check("bubble_mis", 32'(MisalignW), 32'd0);
        end
        adv_prev = !StallM;
      end else begin
        adv_prev = 1'b0;
      end
    end
  end

  logic [31:0] pc_ctr = 32'h0000_0100;

  task automatic drive_m(input logic [2:0] f3, input logic mr, input logic mw,
                         input logic rw, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] wd);
    Funct3M    = f3;
    MemReadM   = mr;
    MemWriteM  = mw;
    RegWriteM  = rw;
    RdM        = rd;
    ALUResultM = alu;
    WriteDataM = wd;
    pc_ctr     = pc_ctr + 32'd4;
    PCPlus4M   = pc_ctr;
  endtask

  function automatic req_t req_m(input logic [2:0] f3, input logic mw,
                                 input logic [31:0] alu, input logic [31:0] wd);
    req_t r;
    r.addr  = alu & 32'hFFFF_FFFC;
    r.we    = mw;
    r.wstrb = 4'b0000;
    r.wdata = 32'h0;
    if (mw) begin
      case (f3[1:0])
        2'b00: begin r.wstrb = 4'b0001 << alu[1:0]; r.wdata = {4{wd[7:0]}}; end
        2'b01: begin r.wstrb = (alu[1:0] == 2'd0) ? 4'b0011 : 4'b1100; r.wdata = {2{wd[15:0]}}; end
        default: begin r.wstrb = 4'b1111; r.wdata = wd; end
      endcase
    end
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the retiring edge.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic mr,
                        input logic mw, input logic rw, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] rdv, input int dly, input int exp_stall);
    logic mem, ok;
    int stalls;
    bit done;
    wb_t e;
    mem = mr | mw;
    ok  = legal_m(f3, alu[1:0]);
    drive_m(f3, mr, mw, rw, rd, alu, wd);
    ready_dly = dly;
    mem_rdata = rdv;
    if (mem && ok) req_q.push_back(req_m(f3, mw, alu, wd));
    e.alu   = alu;
    e.pc    = PCPlus4M;
    e.rd    = rd;
    e.mis   = mem && !ok;
    e.rw    = rw && !(mem && !ok);
    e.rdata = (mem && ok && !mw) ? load_m(f3, alu[1:0], rdv) : 32'h0;
    wb_q.push_back(e);
    stalls = 0;
    done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (!StallM) done = 1;
      else stalls++;
    end
    if (!done) check({tag, "_timeout"}, 32'(StallM), 32'd0);
    check({tag, "_stall"}, 32'(stalls), 32'(exp_stall));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rdata = '0;
    drive_m(3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #12;
    check("rst_stall",  32'(StallM),         32'd0);
    check("rst_valid",  32'(dmem_req_valid), 32'd0);
    check("rst_addr",   dmem_addr,           32'h0);
    check("rst_wstrb",  32'(dmem_wstrb),     32'd0);
    check("rst_aluw",   ALUResultW,          32'h0);
    check("rst_rw",     32'(RegWriteW),      32'd0);
    check("rst_mis",    32'(MisalignW),      32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    mon_on = 1'b1;

    run_op("pass",   3'b000, 1'b0, 1'b0, 1'b1, 5'd5,  32'h0000_1234, 32'h0, 32'h0, 0, 0);
    run_op("lb",     F3_B,   1'b1, 1'b0, 1'b1, 5'd7,  32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 2);
    run_op("lbu",    F3_BU,  1'b1, 1'b0, 1'b1, 5'd8,  32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 2);
    run_op("sh",     F3_H,   1'b0, 1'b1, 1'b0, 5'd0,  32'h0000_2002, 32'h0000_ABCD, 32'h5555_5555, 0, 2);
    run_op("bp_lw",  F3_W,   1'b1, 1'b0, 1'b1, 5'd9,  32'h0000_4000, 32'h0, 32'h1234_5678, 5, 7);
    run_op("mis_lw", F3_W,   1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_3001, 32'h0, 32'h0, 0, 0);
    run_op("lh",     F3_H,   1'b1, 1'b0, 1'b1, 5'd11, 32'h0000_1002, 32'h0, 32'h8001_7FFF, 1, 3);
    run_op("lhu",    F3_HU,  1'b1, 1'b0, 1'b1, 5'd12, 32'h0000_1000, 32'h0, 32'h8001_F00F, 0, 2);
    run_op("sb",     F3_B,   1'b0, 1'b1, 1'b1, 5'd13, 32'h0000_5001, 32'h1234_56A5, 32'h0, 0, 2);
    run_op("mis_sh", F3_H,   1'b0, 1'b1, 1'b0, 5'd14, 32'h0000_3003, 32'h0000_1111, 32'h0, 0, 0);
    run_op("bad_f3", 3'b011, 1'b1, 1'b0, 1'b1, 5'd15, 32'h0000_3000, 32'h0, 32'h0, 0, 0);
    run_op("rw_sw",  F3_W,   1'b1, 1'b1, 1'b1, 5'd16, 32'h0000_7000, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 2, 4);
    run_op("lb_pos", F3_B,   1'b1, 1'b0, 1'b1, 5'd17, 32'h0000_1001, 32'h0, 32'h0000_7F00, 0, 2);
    run_op("pass2",  3'b110, 1'b0, 1'b0, 1'b1, 5'd31, 32'hCAFE_F00D, 32'h0, 32'h0, 0, 0);
    run_op("idle",   3'b000, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    #1;
    mon_on = 1'b0;

    // Reset while waiting for a response
    @(posedge clk);
    #1;
    no_rsp    = 1'b1;
    ready_dly = 0;
    drive_m(F3_W, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_4000, 32'h0);
    req_q.push_back(req_m(F3_W, 1'b0, 32'h0000_4000, 32'h0));
    repeat (3) @(negedge clk);
    check("resp_stall", 32'(StallM), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("mrst_stall", 32'(StallM),         32'd0);
    check("mrst_valid", 32'(dmem_req_valid), 32'd0);
    check("mrst_addr",  dmem_addr,           32'h0);
    check("mrst_aluw",  ALUResultW,          32'h0);
    check("mrst_pcw",   PCPlus4W,            32'h0);
    check("mrst_rdw",   32'(RdW),            32'd0);
    check("mrst_rw",    32'(RegWriteW),      32'd0);
    resp_en  = 1'b0;
    accepted = 1'b0;
    in_req   = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    drive_m(3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #2;
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    dmem_rsp_valid = 1'b0;
    @(negedge clk);
    check("idle_rsp_rw",    32'(RegWriteW),      32'd0);
    check("idle_rsp_rdata", ReadDataW,           32'h0);
    check("idle_rsp_stall", 32'(StallM),         32'd0);
    check("idle_rsp_valid", 32'(dmem_req_valid), 32'd0);
    check("wbq_drained",    32'(wb_q.size()),    32'd0);
    check("reqq_drained",   32'(req_q.size()),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
